// File: rtl/chacha_stream_ctrl.sv
// Host-side initiator for a byte-serial ChaCha core: loads key/counter/nonce, then XORs keystream with plaintext.
// Define CHACHA_OUT_REG_EN to insert a one-entry output register after the XOR (default: combinational path).
module chacha_stream_ctrl #(
  parameter int LOAD_BYTES  = 48,
  parameter int BLOCK_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [5:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  input  logic       stop,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] core_data_out,
  output logic       core_write,
  output logic       core_read,
  input  logic       core_ready,
  input  logic [7:0] core_data_in,
  output logic       busy,
  output logic       ctr_wrap
);

  localparam logic [5:0] LAST_LOAD = 6'(LOAD_BYTES - 1);
  localparam logic [5:0] LAST_RD   = 6'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, STREAM} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  load_idx_reg, load_idx_next;
  logic [5:0]  rd_idx_reg, rd_idx_next;
  logic [7:0]  key_reg [32];
  logic [7:0]  nonce_reg [12];
  logic [31:0] ctr_reg;
  logic        ctr_wrap_reg;
  logic        ctr_inc;
  logic        cfg_en;
  logic        take;
  logic [7:0]  mat_byte;

`ifdef CHACHA_OUT_REG_EN
  logic        out_valid_reg;
  logic [7:0]  out_data_reg;
  logic        blk_end_reg, blk_end_next;
  logic        drain;
`endif

  assign cfg_en   = cfg_we && (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign ctr_wrap = ctr_wrap_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) key_reg[i] <= '0;
      for (int i = 0; i < 12; i++) nonce_reg[i] <= '0;
    end else if (cfg_en) begin
      if (!cfg_addr[5])
        key_reg[cfg_addr[4:0]] <= cfg_data;
      else if (cfg_addr >= 6'd36 && cfg_addr < 6'd48)
        nonce_reg[4'(cfg_addr - 6'd36)] <= cfg_data;
    end
  end

  // Increment happens only in STREAM and config only in IDLE, so they never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr_reg      <= '0;
      ctr_wrap_reg <= 1'b0;
    end else if (ctr_inc) begin
      ctr_reg <= ctr_reg + 32'd1;
      if (&ctr_reg) ctr_wrap_reg <= 1'b1;
    end else if (cfg_en && cfg_addr[5:2] == 4'd8) begin
      ctr_reg[{cfg_addr[1:0], 3'b000} +: 8] <= cfg_data;
      ctr_wrap_reg <= 1'b0;
    end
  end

  always_comb begin
    mat_byte = '0;
    if (load_idx_reg < 6'd32)
      mat_byte = key_reg[load_idx_reg[4:0]];
    else if (load_idx_reg < 6'd36)
      mat_byte = ctr_reg[{load_idx_reg[1:0], 3'b000} +: 8];
    else if (load_idx_reg < 6'd48)
      mat_byte = nonce_reg[4'(load_idx_reg - 6'd36)];
  end

  assign core_data_out = core_write ? mat_byte : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      load_idx_reg <= '0;
      rd_idx_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      load_idx_reg <= load_idx_next;
      rd_idx_reg   <= rd_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    load_idx_next = load_idx_reg;
    rd_idx_next   = rd_idx_reg;
    ctr_inc       = 1'b0;
    core_write    = 1'b0;
    core_read     = 1'b0;
    in_ready      = 1'b0;
    take          = 1'b0;
`ifdef CHACHA_OUT_REG_EN
    blk_end_next  = blk_end_reg;
    drain         = 1'b0;
`else
    out_valid     = 1'b0;
    out_data      = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        core_write = 1'b1;
        if (load_idx_reg == LAST_LOAD) begin
          load_idx_next = '0;
          state_next    = WAIT;
        end else begin
          load_idx_next = load_idx_reg + 6'd1;
        end
      end
      WAIT: begin
        if (stop)            state_next = IDLE;
        else if (core_ready) state_next = STREAM;
      end
      STREAM: begin
`ifdef CHACHA_OUT_REG_EN
        drain    = stop || blk_end_reg;
        in_ready = !drain && (!out_valid_reg || out_ready);
`else
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data ^ core_data_in;
`endif
        take      = in_valid && in_ready;
        core_read = take;
        if (take) begin
          if (rd_idx_reg == LAST_RD) begin
            rd_idx_next = '0;
            ctr_inc     = 1'b1;
`ifdef CHACHA_OUT_REG_EN
            blk_end_next = 1'b1;
`else
            state_next = stop ? IDLE : LOAD;
`endif
          end else begin
            rd_idx_next = rd_idx_reg + 6'd1;
          end
        end
`ifdef CHACHA_OUT_REG_EN
        // Leave only once the output register is empty so no ciphertext is stranded.
        if (drain && !out_valid_reg) begin
          state_next   = stop ? IDLE : LOAD;
          rd_idx_next  = '0;
          blk_end_next = 1'b0;
        end
`else
        if (stop) begin
          state_next  = IDLE;
          rd_idx_next = '0;
        end
`endif
      end
      default: ;
    endcase
  end

`ifdef CHACHA_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      blk_end_reg   <= 1'b0;
    end else begin
      blk_end_reg <= blk_end_next;
      if (take) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data ^ core_data_in;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
`endif

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Self-checking bench for chacha_stream_ctrl: behavioural ChaCha core, keystream scoreboard, RFC 8439 vector table.
module tb_chacha_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       start, stop;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [7:0] core_data_out;
  logic       core_write, core_read;
  logic       core_ready;
  logic [7:0] core_data_in;
  logic       busy, ctr_wrap;

  int checks = 0;
  int errors = 0;
  int timeouts = 0;

  always #5 clk = ~clk;

  chacha_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_data_out(core_data_out), .core_write(core_write), .core_read(core_read),
    .core_ready(core_ready), .core_data_in(core_data_in),
    .busy(busy), .ctr_wrap(ctr_wrap)
  );

  // ---------------- ChaCha20 reference ----------------
  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [255:0] key, input logic [31:0] ctr,
                                                input logic [95:0] nonce);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = nonce[32*i +: 32];
    x = s;
    for (int rnd = 0; rnd < 10; rnd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // ---------------- behavioural core ----------------
  logic [7:0]   lbuf [48];
  logic [511:0] core_ks;
  logic [5:0]   raddr;
  int           widx, dly_cnt;
  int           core_dly = 4;
  logic [255:0] cm_key;
  logic [95:0]  cm_nonce;
  logic [31:0]  cm_ctr;
  logic [31:0]  load_ctr_q [$];

  always @(posedge clk) begin
    if (!rst_n) begin
      widx = 0; dly_cnt = 0;
      raddr <= '0; core_ready <= 1'b0; core_ks <= '0;
    end else begin
      if (core_write) begin
        lbuf[widx] = core_data_out;
        core_ready <= 1'b0;
        widx++;
        if (widx == 48) begin
          widx = 0;
          for (int i = 0; i < 32; i++) cm_key[8*i +: 8] = lbuf[i];
          for (int i = 0; i < 12; i++) cm_nonce[8*i +: 8] = lbuf[36+i];
          cm_ctr = {lbuf[35], lbuf[34], lbuf[33], lbuf[32]};
          core_ks <= chacha_block(cm_key, cm_ctr, cm_nonce);
          raddr   <= '0;
          dly_cnt = core_dly;
          load_ctr_q.push_back(cm_ctr);
        end
      end else if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) core_ready <= 1'b1;
      end
      if (core_read) raddr <= raddr + 6'd1;
    end
  end

  assign core_data_in = core_ks[{raddr, 3'b000} +: 8];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Scoreboard: expected ciphertext is pushed when plaintext is accepted, popped when ciphertext leaves.
  logic [255:0] model_key;
  logic [95:0]  model_nonce;
  logic [31:0]  model_ctr;
  logic [511:0] model_ks;
  int           model_idx;
  logic [7:0]   sb [$];
  logic [7:0]   ct_log [$];
  int           wr_cnt, first_rd_wr;

  task automatic model_set(input logic [31:0] c);
    model_ctr = c;
    model_idx = 0;
    model_ks  = chacha_block(model_key, c, model_nonce);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_write) wr_cnt++;
      if (core_read && first_rd_wr < 0) first_rd_wr = wr_cnt;
      if (in_valid && in_ready) begin
        sb.push_back(in_data ^ model_ks[8*model_idx +: 8]);
        model_idx++;
        if (model_idx == 64) begin
          model_idx = 0;
          model_ctr = model_ctr + 32'd1;
          model_ks  = chacha_block(model_key, model_ctr, model_nonce);
        end
      end
      if (out_valid && out_ready) begin
        ct_log.push_back(out_data);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL ct_unexpected actual=%02h required=none", out_data);
        end else begin
          check("ct", {24'h0, out_data}, {24'h0, sb.pop_front()});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic configure(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
    for (int i = 0; i < 32; i++) cfg_write(6'(i), k[8*i +: 8]);
    for (int i = 0; i < 4; i++)  cfg_write(6'(32 + i), c[8*i +: 8]);
    for (int i = 0; i < 12; i++) cfg_write(6'(36 + i), n[8*i +: 8]);
    model_key = k; model_nonce = n;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gaps);
    int cyc = 0;
    bit hs = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d;
    while (!hs && cyc < 400) begin
      out_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!hs) timeouts++;
  endtask

  task automatic stream(input int n, input bit gaps, input bit zero_data);
    int t0 = timeouts;
    for (int i = 0; i < n; i++) send_byte(zero_data ? 8'h00 : 8'($urandom), gaps);
    out_ready = 1'b0;
    check("stream_timeouts", 32'(timeouts - t0), 0);
  endtask

  task automatic go_idle();
    int cyc = 0;
    stop = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    while (busy && cyc < 500) begin @(negedge clk); cyc++; end
    check("go_idle_busy", {31'h0, busy}, 0);
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] pt;
    logic [7:0] exp_ct;
  } vec_t;

  vec_t         rfc_tbl [8];
  logic [255:0] key_v;
  logic [95:0]  nonce_v;
  logic [7:0]   kor;
  int           stall, bad, cyc;

  initial begin
    rfc_tbl[0] = '{0, 8'h00, 8'h10}; rfc_tbl[1] = '{1, 8'h00, 8'hf1};
    rfc_tbl[2] = '{2, 8'h00, 8'he7}; rfc_tbl[3] = '{3, 8'h00, 8'he4};
    rfc_tbl[4] = '{4, 8'h00, 8'hd1}; rfc_tbl[5] = '{5, 8'h00, 8'h3b};
    rfc_tbl[6] = '{6, 8'h00, 8'h59}; rfc_tbl[7] = '{7, 8'h00, 8'h15};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    wr_cnt = 0; first_rd_wr = -1;
    model_key = '0; model_nonce = '0; model_set(0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_core_write", {31'h0, core_write}, 0);
    check("rst_core_read", {31'h0, core_read}, 0);
    check("rst_in_ready", {31'h0, in_ready}, 0);
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_ctr_wrap", {31'h0, ctr_wrap}, 0);
    @(posedge clk); #1;

    // RFC 8439 2.3.2 block, driven from the vector table then zeros
    for (int i = 0; i < 32; i++) key_v[8*i +: 8] = 8'(i);
    nonce_v = '0; nonce_v[8*3 +: 8] = 8'h09; nonce_v[8*7 +: 8] = 8'h4a;
    configure(key_v, 32'd1, nonce_v);
    model_set(32'd1);
    wr_cnt = 0; first_rd_wr = -1; ct_log.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(rfc_tbl[i].pt, 1'b0);
    stream(56, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      check($sformatf("rfc_ct%0d", rfc_tbl[i].idx), {24'h0, ct_log[rfc_tbl[i].idx]}, {24'h0, rfc_tbl[i].exp_ct});
    check("writes_before_read", 32'(first_rd_wr), 48);
    go_idle();

    // Slow core: no reads and no in_ready until ready, stream starts the cycle after
    core_dly = 30;
    model_set(32'd2);
    load_ctr_q.delete();
    in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'b1;
    pulse_start();
    cyc = 0;
    @(negedge clk);
    while (core_write && cyc < 100) begin @(negedge clk); cyc++; end
    stall = 0; bad = 0;
    while (!core_ready && stall < 200) begin
      if (in_ready || core_read) bad++;
      stall++;
      @(negedge clk);
    end
    check("wait_stall_cycles", 32'(stall), 30);
    check("wait_no_read", 32'(bad), 0);
    check("ready_cycle_in_ready", {31'h0, in_ready}, 0);
    @(negedge clk);
    check("stream_in_ready", {31'h0, in_ready}, 1);
    check("stream_core_read", {31'h0, core_read}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    stream(63, 1'b1, 1'b0);
    check("resume_load_ctr", load_ctr_q[0], 32'd2);
    go_idle();
    core_dly = 4;

    // 130 bytes with random gaps: two automatic reloads
    key_v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    nonce_v = {$urandom, $urandom, $urandom};
    configure(key_v, 32'd1, nonce_v);
    model_set(32'd1);
    load_ctr_q.delete();
    pulse_start();
    stream(130, 1'b1, 1'b0);
    go_idle();
    check("reload_count", 32'(load_ctr_q.size()), 3);
    check("load2_ctr", load_ctr_q[1], 32'd2);
    check("load3_ctr", load_ctr_q[2], 32'd3);

    // stop at rd_idx=10 with out_ready low
    model_set(32'd3);
    load_ctr_q.delete();
    pulse_start();
    stream(10, 1'b0, 1'b0);
    stop = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("stop_busy", {31'h0, busy}, 0);
    check("stop_in_ready", {31'h0, in_ready}, 0);
    stop = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("stop_load_ctr", load_ctr_q[0], 32'd3);
    model_set(32'd3);
    load_ctr_q.delete();
    pulse_start();
    stream(64, 1'b0, 1'b0);
    check("restart_load_ctr", load_ctr_q[0], 32'd3);
    go_idle();

    // counter wrap
    for (int i = 0; i < 4; i++) cfg_write(6'(32 + i), 8'hff);
    model_set(32'hffff_ffff);
    load_ctr_q.delete();
    pulse_start();
    stream(63, 1'b1, 1'b0);
    check("wrap_before", {31'h0, ctr_wrap}, 0);
    stream(1, 1'b1, 1'b0);
    check("wrap_after", {31'h0, ctr_wrap}, 1);
    stream(1, 1'b1, 1'b0);
    check("wrap_load_ctr", load_ctr_q[1], 32'd0);
    go_idle();
    check("wrap_sticky", {31'h0, ctr_wrap}, 1);
    cfg_write(6'd33, 8'h00);
    check("wrap_cfg_clear", {31'h0, ctr_wrap}, 0);

    // reset during LOAD at load_idx=20
    pulse_start();
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_load_core_write", {31'h0, core_write}, 0);
    check("rst_load_busy", {31'h0, busy}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
    load_ctr_q.delete();
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 8'h5a; start = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    cyc = 0;
    while (load_ctr_q.size() == 0 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("post_rst_loads", 32'(load_ctr_q.size()), 1);
    check("cfg_with_start_byte0", {24'h0, lbuf[0]}, 32'h5a);
    kor = '0;
    for (int i = 1; i < 48; i++) kor |= lbuf[i];
    check("post_rst_material_zero", {24'h0, kor}, 0);
    go_idle();

    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha_stream_ctrl.md
Name: chacha_stream_ctrl

Overview:
Host-side initiator for the byte-serial ChaCha block core. It holds key, nonce and 32-bit block counter. It drives the core's write strobe to load 48 bytes of key/counter/nonce material, then waits for the core's ready. It then issues read strobes to pull 64 keystream bytes, XORing each with a valid/ready plaintext stream to produce ciphertext. After each block it increments the counter and reloads the core automatically until stopped.

Parameters:
LOAD_BYTES, 48, bytes written to core per block (key 0-31, counter 32-35 little-endian, nonce 36-47)
BLOCK_BYTES, 64, keystream bytes read from core per block

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active-low
cfg_we  input  1  config byte write strobe; honoured only in IDLE
cfg_addr  input  6  config byte address 0-47 (same layout as LOAD); 48-63 ignored
cfg_data  input  8  config byte
start  input  1  one-cycle pulse; begins streaming from IDLE
stop  input  1  level; finish current byte, then return to IDLE
in_valid  input  1  plaintext byte valid
in_ready  output  1  plaintext byte accepted
in_data  input  8  plaintext byte
out_valid  output  1  ciphertext byte valid
out_ready  input  1  downstream can accept
out_data  output  8  ciphertext byte
core_data_out  output  8  to core data_in
core_write  output  1  to core write strobe
core_read  output  1  to core read strobe
core_ready  input  1  from core ready
core_data_in  input  8  from core data_out (current keystream byte, combinational from core address)
busy  output  1  state != IDLE
ctr_wrap  output  1  sticky; set when counter wraps 0xFFFFFFFF->0; cleared by cfg write to addr 32-35 or reset

Behaviour:
- Reset: state IDLE. Key, nonce and counter registers become 0. load_idx=0, rd_idx=0. All outputs 0 (core_write, core_read, in_ready, out_valid, busy, ctr_wrap). Reset mid-block abandons the block. The core is not re-synchronised except via its own reset, which shares rst_n.
- IDLE: cfg_we writes cfg_data to byte cfg_addr. start -> LOAD. If cfg_we and start occur together, the write lands first and LOAD uses the new byte.
- LOAD: exactly LOAD_BYTES consecutive cycles with core_write=1. core_data_out = material[load_idx], load_idx 0..47. Counter bytes come from the live counter register. After byte 47 -> WAIT, load_idx=0. stop is ignored in LOAD; the load always completes.
- WAIT: core_write=0. Move to STREAM on the first cycle core_ready=1, never in the same cycle as the last write. If stop=1 while waiting -> IDLE.
- STREAM (default, unregistered path): xfer = in_valid & out_ready.
  - in_ready = out_ready; out_valid = in_valid; out_data = in_data ^ core_data_in; core_read = xfer.
  - Each xfer increments rd_idx.
  - On xfer with rd_idx=63: counter += 1 (mod 2^32; on wrap set ctr_wrap), rd_idx=0. Then -> IDLE if stop, else LOAD.
  - stop with no xfer this cycle -> IDLE immediately; remaining keystream is discarded and the counter is not incremented.
- Counter persists across IDLE; a subsequent start resumes at the next block unless reconfigured.
- Throughput: 48 load + core compute + 64 stream cycles per block. in_ready/out_valid are 0 outside STREAM.

Optional Feature:
CHACHA_OUT_REG_EN
- Defined: one-entry output register between the XOR and out_data/out_valid.
  - in_ready = !out_valid_q | out_ready; core_read = in_valid & in_ready.
  - Latency is 1 cycle; full throughput with out_ready=1.
  - stop and the block-end transition wait until the register drains, so out_valid_q=0 before leaving STREAM.
- Undefined: combinational path as above, 0-cycle latency.

Test Plan:
- RFC 8439 sect. 2.3.2 vector: key 00..1f, counter 1, nonce 00000009 0000004a 00000000, 64 zero plaintext bytes with out_ready=1 -> out_data begins 10 f1 e7 e4 d1 3b 59 15. Exactly 48 core_write cycles precede the first core_read.
- Core model holds core_ready low 30 cycles after load -> no core_read and in_ready=0 throughout; streaming starts the cycle after ready rises.
- 130 plaintext bytes with random in_valid/out_ready gaps -> two reloads. The second and third loads carry counter bytes 02 00 00 00 and 03 00 00 00; ciphertext matches the reference model.
- Counter preset FF FF FF FF, stream 65 bytes -> ctr_wrap=1 after byte 64; the next load carries 00 00 00 00.
- stop asserted at rd_idx=10 with out_ready=0 -> IDLE next cycle, busy=0, counter unchanged. start then reloads the same counter.
- rst_n low during LOAD at load_idx=20 -> next cycle core_write=0, busy=0, key registers read back 0.
